// File: rtl/design_select_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// design_sel_pkg
// Shared definitions for the design select sequencer of the 12-slot
// multi-design harness.
//   seq_state_t  : sequencer states (IDLE, DRAIN, HOLD, RUN)
//   SEL_NONE     : select code meaning "no design selected"
//   MAX_DESIGNS  : number of designs hosted by the harness
// ---------------------------------------------------------------------------
package design_sel_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2,
      RUN   = 2'd3
   } seq_state_t;

   localparam logic [3:0] SEL_NONE    = 4'd0;
   localparam int         MAX_DESIGNS = 12;

endpackage

// File: rtl/design_select_sequencer.sv
// ---------------------------------------------------------------------------
// design_select_sequencer
// Sequences design switchovers in front of the design multiplexer. Every
// accepted request first parks all GPIOs (select 0) for GUARD_CYCLES, then
// presents the new select with reset held for RESET_CYCLES, then releases
// reset. Outgoing and incoming designs never share a cycle on the pads.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   req_valid      select request strobe
//   req_select     requested design code, 0 deselects all
//   req_ready      request can be accepted (IDLE or RUN)
//   design_select  select code to the multiplexer
//   design_n_rst   active-low reset to the multiplexer
//   active         selected design is running
//   err_invalid    sticky: an out-of-range request was dropped
// ---------------------------------------------------------------------------
module design_select_sequencer
   import design_sel_pkg::*;
#(
   parameter int NUM_DESIGNS  = MAX_DESIGNS,
   parameter int GUARD_CYCLES = 4,
   parameter int RESET_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [3:0] req_select,
   output logic       req_ready,
   output logic [3:0] design_select,
   output logic       design_n_rst,
   output logic       active,
   output logic       err_invalid
);

   // The counter only has to hold the larger of the two load values; a
   // minimum width of 1 keeps the vector legal when both phases are 1 cycle.
   localparam int MAX_CYC = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
   localparam logic [4:0]       MAX_CODE   = 5'(NUM_DESIGNS);

   seq_state_t       state, state_next;
   logic [3:0]       target, target_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             err_next;

   // State, accepted target, phase counter and the sticky error flag. The
   // pending target is deliberately discarded on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         target      <= SEL_NONE;
         cnt         <= '0;
         err_invalid <= 1'b0;
      end else begin
         state       <= state_next;
         target      <= target_next;
         cnt         <= cnt_next;
         err_invalid <= err_next;
      end
   end

   // Output decode and next-state logic. Outputs depend only on the
   // registered state and target; the request only steers next-state values.
   // An accepted request is only possible in IDLE or RUN, so it overrides the
   // phase timing that applies to DRAIN and HOLD. The mux reset is forced
   // low while rst is high so the downstream design is held immediately.
   always_comb begin
      state_next    = state;
      target_next   = target;
      cnt_next      = cnt;
      err_next      = err_invalid;
      req_ready     = 1'b0;
      design_select = SEL_NONE;
      design_n_rst  = 1'b1;
      active        = 1'b0;

      case (state)
         IDLE: begin
            req_ready = 1'b1;
         end
         DRAIN: begin
            if (cnt == '0) begin
               if (target == SEL_NONE) begin
                  state_next = IDLE;
               end else begin
                  state_next = HOLD;
                  cnt_next   = RESET_LOAD;
               end
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         HOLD: begin
            design_select = target;
            design_n_rst  = 1'b0;
            if (cnt == '0) begin
               state_next = RUN;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         RUN: begin
            req_ready     = 1'b1;
            design_select = target;
            active        = 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (req_valid && req_ready) begin
         if ({1'b0, req_select} > MAX_CODE) begin
            err_next = 1'b1;
         end else begin
            target_next = req_select;
            err_next    = 1'b0;
            state_next  = DRAIN;
            cnt_next    = GUARD_LOAD;
         end
      end

      if (rst) begin
         design_n_rst = 1'b0;
      end
   end

endmodule

// File: tb/tb_design_select_sequencer.sv
// ---------------------------------------------------------------------------
// tb_design_select_sequencer
// Drives directed and random select requests into design_select_sequencer
// and compares every cycle against a timeline model: the model only records
// when the last valid request was taken and what it asked for, and derives
// the expected outputs from the elapsed cycle count.
// ---------------------------------------------------------------------------
module tb_design_select_sequencer;

   localparam int G    = 4;
   localparam int R    = 8;
   localparam int NDES = 12;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic [3:0] req_select;
   logic       req_ready;
   logic [3:0] design_select;
   logic       design_n_rst;
   logic       active;
   logic       err_invalid;

   int errors = 0;
   int checks = 0;

   design_select_sequencer #(
      .NUM_DESIGNS (NDES),
      .GUARD_CYCLES(G),
      .RESET_CYCLES(R)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_select   (req_select),
      .req_ready    (req_ready),
      .design_select(design_select),
      .design_n_rst (design_n_rst),
      .active       (active),
      .err_invalid  (err_invalid)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Timeline model: m_busy means a sequence was started by an accepted
   // request, m_elapsed counts clock edges since that acceptance.
   bit         m_busy;
   int         m_elapsed;
   logic [3:0] m_target;
   bit         m_err;

   function automatic bit m_drain();
      return m_busy && (m_elapsed < G);
   endfunction

   function automatic bit m_hold();
      return m_busy && (m_target != 4'd0) && (m_elapsed >= G) && (m_elapsed < G + R);
   endfunction

   function automatic bit m_run();
      return m_busy && (m_target != 4'd0) && (m_elapsed >= G + R);
   endfunction

   function automatic bit m_ready();
      return !(m_drain() || m_hold());
   endfunction

   // Advance the model on every edge using the same inputs the DUT sees.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy    = 1'b0;
         m_elapsed = 0;
         m_target  = 4'd0;
         m_err     = 1'b0;
      end else begin
         bit rdy;
         rdy = m_ready();
         if (m_busy) m_elapsed = m_elapsed + 1;
         if (m_busy && m_target == 4'd0 && m_elapsed >= G) m_busy = 1'b0;
         if (req_valid && rdy) begin
            if (int'(req_select) > NDES) begin
               m_err = 1'b1;
            end else begin
               m_target  = req_select;
               m_err     = 1'b0;
               m_busy    = 1'b1;
               m_elapsed = 0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison on the falling edge, plus a guard that two
   // different nonzero codes never appear back to back.
   logic [3:0] prev_sel = 4'd0;
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rst_select", int'(design_select), 0);
         checkOutput("rst_n_rst", int'(design_n_rst), 0);
         checkOutput("rst_ready", int'(req_ready), 1);
         checkOutput("rst_active", int'(active), 0);
         checkOutput("rst_err", int'(err_invalid), 0);
      end else begin
         checkOutput("model_select", int'(design_select),
                     (m_hold() || m_run()) ? int'(m_target) : 0);
         checkOutput("model_n_rst", int'(design_n_rst), m_hold() ? 0 : 1);
         checkOutput("model_ready", int'(req_ready), m_ready() ? 1 : 0);
         checkOutput("model_active", int'(active), m_run() ? 1 : 0);
         checkOutput("model_err", int'(err_invalid), m_err ? 1 : 0);
      end
      if (prev_sel != 4'd0 && design_select != 4'd0) begin
         checkOutput("no_direct_switch", int'(design_select), int'(prev_sel));
      end
      prev_sel = design_select;
   end

   // One-cycle request pulse; the second rising edge inside is the edge at
   // which the request is sampled. Returns 2 ns after that edge.
   task automatic applyStimulus(input logic v, input logic [3:0] s);
      @(posedge clk);
      #2;
      req_valid  = v;
      req_select = s;
      @(posedge clk);
      #2;
      req_valid  = 1'b0;
   endtask

   task automatic wait_active(input int budget);
      int n;
      n = 0;
      while (!active && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("wait_active_timeout", int'(active), 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_select = 4'd0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("release_n_rst", int'(design_n_rst), 1);
      checkOutput("release_select", int'(design_select), 0);

      // Select 5 from IDLE: 4 cycles parked, 8 in reset, then running.
      applyStimulus(1'b1, 4'd5);
      checkOutput("sel5_drain_select", int'(design_select), 0);
      checkOutput("sel5_drain_ready", int'(req_ready), 0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("sel5_hold_select", int'(design_select), 5);
      checkOutput("sel5_hold_n_rst", int'(design_n_rst), 0);
      repeat (7) @(posedge clk);
      #1;
      checkOutput("sel5_not_yet_active", int'(active), 0);
      @(posedge clk);
      #1;
      checkOutput("sel5_active", int'(active), 1);
      checkOutput("sel5_run_select", int'(design_select), 5);

      // Switch 5 -> 9 through a full drain.
      applyStimulus(1'b1, 4'd9);
      checkOutput("sw9_drain_select", int'(design_select), 0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("sw9_hold_select", int'(design_select), 9);
      checkOutput("sw9_hold_n_rst", int'(design_n_rst), 0);
      repeat (8) @(posedge clk);
      #1;
      checkOutput("sw9_active", int'(active), 1);
      checkOutput("sw9_run_n_rst", int'(design_n_rst), 1);

      // Out-of-range code is dropped and flagged.
      applyStimulus(1'b1, 4'd14);
      checkOutput("inv_err", int'(err_invalid), 1);
      checkOutput("inv_select", int'(design_select), 9);
      checkOutput("inv_active", int'(active), 1);

      // Deselect clears the flag and lands in IDLE after the guard time.
      applyStimulus(1'b1, 4'd0);
      checkOutput("desel_err_clear", int'(err_invalid), 0);
      checkOutput("desel_drain_ready", int'(req_ready), 0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("desel_idle_ready", int'(req_ready), 1);
      checkOutput("desel_idle_select", int'(design_select), 0);
      checkOutput("desel_idle_active", int'(active), 0);

      // Requests while busy are ignored.
      applyStimulus(1'b1, 4'd7);
      applyStimulus(1'b1, 4'd3);
      repeat (4) @(posedge clk);
      applyStimulus(1'b1, 4'd3);
      wait_active(30);
      checkOutput("ignore_select", int'(design_select), 7);

      // Random traffic, checked by the model every cycle.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #2;
         req_valid  = ($urandom_range(0, 3) == 0);
         req_select = 4'($urandom_range(0, 15));
      end
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      repeat (30) @(posedge clk);

      // Asynchronous reset in the middle of HOLD.
      applyStimulus(1'b1, 4'd2);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("pre_rst_hold_n_rst", int'(design_n_rst), 0);
      checkOutput("pre_rst_hold_select", int'(design_select), 2);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_select", int'(design_select), 0);
      checkOutput("async_rst_n_rst", int'(design_n_rst), 0);
      checkOutput("async_rst_ready", int'(req_ready), 1);
      checkOutput("async_rst_active", int'(active), 0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_select", int'(design_select), 0);
      checkOutput("post_rst_n_rst", int'(design_n_rst), 1);
      checkOutput("post_rst_ready", int'(req_ready), 1);
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/design_select_sequencer.md
# design_select_sequencer

Sequences design switchovers for the 12-slot multi-design harness. Sits directly upstream of the design multiplexer and drives its `design_select` and `n_rst` inputs. On each accepted select request it first parks every GPIO as an input with no design selected, then presents the new select with reset held, then releases reset. Outgoing and incoming designs therefore never drive pads in the same cycle, and the incoming design always starts from a clean reset.

## Interface
Parameters:
- `NUM_DESIGNS`, 12: highest valid select code; valid codes are 0..NUM_DESIGNS.
- `GUARD_CYCLES`, 4: cycles with select forced to 0 before the new design appears; must be ≥1.
- `RESET_CYCLES`, 8: cycles the new design is held in reset; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  select request strobe.
- `req_select`  in  4  requested design code; 0 means deselect all.
- `req_ready`  out  1  high in IDLE and RUN only.
- `design_select`  out  4  to the multiplexer `design_select`.
- `design_n_rst`  out  1  to the multiplexer `n_rst`, active low.
- `active`  out  1  high only in RUN.
- `err_invalid`  out  1  sticky flag: a request with an out-of-range code was dropped.

## Operation
- States: IDLE, DRAIN, HOLD, RUN. Register `target[3:0]` holds the accepted code.
- Handshake: accept = `req_valid && req_ready`. No request is queued; while `req_ready` is low, `req_valid` is ignored.
- Accept with `req_select > NUM_DESIGNS`: state, target and outputs unchanged; `err_invalid` set to 1.
- Accept with a valid code: load target, clear `err_invalid`, go to DRAIN, load counter with GUARD_CYCLES-1.
- DRAIN: `design_select`=0, `design_n_rst`=1. On counter==0:
  - if target==0, go to IDLE;
  - otherwise go to HOLD and load counter with RESET_CYCLES-1.
- HOLD: `design_select`=target, `design_n_rst`=0. On counter==0, go to RUN.
- RUN: `design_select`=target, `design_n_rst`=1, `active`=1.
- IDLE: `design_select`=0, `design_n_rst`=1.
- Re-requesting the current target from RUN runs the full DRAIN/HOLD sequence (restart).
- Every transition out of RUN passes through DRAIN, so `design_select` never steps directly from one nonzero code to another.
- Reset values: state IDLE, target 0, counter 0, `design_select`=0, `design_n_rst`=0 while `rst` is high (1 after release), `req_ready`=1, `active`=0, `err_invalid`=0.

## Timing
- All outputs are decoded from registered state/target only. No combinational path runs from `req_*` to any output.
- Valid request accepted at rising edge k:
  - DRAIN occupies cycles k+1 .. k+GUARD_CYCLES.
  - HOLD occupies the next RESET_CYCLES cycles.
  - RUN is entered at edge k+GUARD_CYCLES+RESET_CYCLES.
- Deselect (code 0) returns to IDLE at edge k+GUARD_CYCLES.
- `err_invalid` rises the cycle after the invalid accept.
- `rst` asserted mid-sequence (any state): outputs take reset values immediately and asynchronously. The pending target is lost.
- Counter width is $clog2(max(GUARD_CYCLES,RESET_CYCLES)). It loads only on state entry and decrements by 1 per cycle, with no wrap.

## Structure
- Package `design_sel_pkg`: state enum `seq_state_t` (IDLE, DRAIN, HOLD, RUN), localparam `SEL_NONE`=4'd0, localparam `MAX_DESIGNS`=12.
- Single module, one always_ff (state/target/counter/err) and one always_comb (outputs, next state). No sub-module is warranted.

## Test plan
- Reset: hold `rst` high for 3 cycles → `design_select`=0, `design_n_rst`=0, `req_ready`=1, `active`=0. Release `rst` → `design_n_rst`=1 next sample.
- Select 5 from IDLE (G=4, R=8), accepted at edge k → `design_select`=0 for 4 cycles, then =5 with `design_n_rst`=0 for 8 cycles, then `active`=1 at edge k+12. `req_ready` is low throughout the 12 cycles.
- Switch 5→9 from RUN → `design_select` goes 5,0×4,9×8(reset),9(run). 5 and 9 are never adjacent.
- Invalid code 14 from RUN on 9 → outputs unchanged, `err_invalid`=1. Next valid request (code 0) → `err_invalid`=0 and IDLE after 4 cycles.
- `req_valid` with code 3 pulsed during DRAIN and HOLD → ignored; the original target reaches RUN.
- `rst` asserted during HOLD (async, mid-cycle) → outputs reach reset values before the next clock edge. After release the block is in IDLE with `design_select`=0.
